// File: rtl/bcam_req_sched.sv
// bcam_req_sched: serialises a write client and a match client onto one binary CAM core.
// Define BCAM_SCHED_STATS_EN to add the stat_wr/stat_mt/stat_hit counter outputs.
module bcam_req_sched #(
    parameter  int CAMD  = 256,
    parameter  int CAMW  = 16,
    parameter  int WLAT  = 2,
    parameter  int MLAT  = 3,
    localparam int ADDRW = $clog2(CAMD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_req,
    input  logic [ADDRW-1:0] w_addr,
    input  logic [CAMW-1:0]  w_patt,
    output logic             w_gnt,
    input  logic             m_req,
    input  logic [CAMW-1:0]  m_patt,
    output logic             m_gnt,
    output logic             m_rsp_vld,
    output logic             m_rsp_hit,
    output logic [ADDRW-1:0] m_rsp_addr,
    output logic             busy,
    output logic             cam_wEnb,
    output logic [ADDRW-1:0] cam_wAddr,
    output logic [CAMW-1:0]  cam_wPatt,
    output logic [CAMW-1:0]  cam_mPatt,
    input  logic             cam_match,
    input  logic [ADDRW-1:0] cam_mAddr
`ifdef BCAM_SCHED_STATS_EN
    ,
    output logic [15:0]      stat_wr,
    output logic [15:0]      stat_mt,
    output logic [15:0]      stat_hit
`endif
);

    localparam int CNTMAX = (WLAT > MLAT) ? WLAT : MLAT;
    localparam int CNTW   = $clog2(CNTMAX + 1);

    // WGNT/MGNT are the grant cycles; the operation proper starts one cycle later
    typedef enum logic [2:0] {
        S_IDLE,
        S_WGNT,
        S_WRITE,
        S_MGNT,
        S_MATCH
    } state_e;

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             rr_q, rr_d;
    logic             w_gnt_q, w_gnt_d;
    logic             m_gnt_q, m_gnt_d;
    logic             vld_q, vld_d;
    logic             hit_q, hit_d;
    logic [ADDRW-1:0] raddr_q, raddr_d;
    logic             busy_q, busy_d;
    logic             wenb_q, wenb_d;
    logic [ADDRW-1:0] waddr_q, waddr_d;
    logic [CAMW-1:0]  wpatt_q, wpatt_d;
    logic [CAMW-1:0]  mpatt_q, mpatt_d;
    logic             arb;
    logic             pick_w;
    logic             pick_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            w_gnt_q <= 1'b0;
            m_gnt_q <= 1'b0;
            vld_q   <= 1'b0;
            hit_q   <= 1'b0;
            raddr_q <= '0;
            busy_q  <= 1'b0;
            wenb_q  <= 1'b0;
            waddr_q <= '0;
            wpatt_q <= '0;
            mpatt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            w_gnt_q <= w_gnt_d;
            m_gnt_q <= m_gnt_d;
            vld_q   <= vld_d;
            hit_q   <= hit_d;
            raddr_q <= raddr_d;
            busy_q  <= busy_d;
            wenb_q  <= wenb_d;
            waddr_q <= waddr_d;
            wpatt_q <= wpatt_d;
            mpatt_q <= mpatt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        w_gnt_d = 1'b0;
        m_gnt_d = 1'b0;
        vld_d   = 1'b0;
        hit_d   = hit_q;
        raddr_d = raddr_q;
        busy_d  = busy_q;
        wenb_d  = 1'b0;
        waddr_d = waddr_q;
        wpatt_d = wpatt_q;
        mpatt_d = mpatt_q;
        arb     = 1'b0;
        pick_w  = 1'b0;
        pick_m  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                arb = 1'b1;
            end
            S_WGNT: begin
                state_d = S_WRITE;
                wenb_d  = 1'b1;
                waddr_d = w_addr;
                wpatt_d = w_patt;
                busy_d  = 1'b1;
                cnt_d   = CNTW'(WLAT - 1);
            end
            S_WRITE: begin
                if (cnt_q == '0) begin
                    busy_d = 1'b0;
                    arb    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_MGNT: begin
                state_d = S_MATCH;
                mpatt_d = m_patt;
                busy_d  = 1'b1;
                cnt_d   = CNTW'(MLAT - 1);
            end
            S_MATCH: begin
                if (cnt_q == '0) begin
                    vld_d   = 1'b1;
                    hit_d   = cam_match;
                    raddr_d = cam_mAddr;
                    busy_d  = 1'b0;
                    arb     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // the last cycle of an operation arbitrates so the next grant lands back-to-back
        if (arb) begin
            state_d = S_IDLE;
            pick_w  = w_req && (!m_req || !rr_q);
            pick_m  = m_req && (!w_req || rr_q);
            if (pick_w) begin
                w_gnt_d = 1'b1;
                state_d = S_WGNT;
                rr_d    = 1'b1;
            end else if (pick_m) begin
                m_gnt_d = 1'b1;
                state_d = S_MGNT;
                rr_d    = 1'b0;
            end
        end
    end

    assign w_gnt      = w_gnt_q;
    assign m_gnt      = m_gnt_q;
    assign m_rsp_vld  = vld_q;
    assign m_rsp_hit  = hit_q;
    assign m_rsp_addr = raddr_q;
    assign busy       = busy_q;
    assign cam_wEnb   = wenb_q;
    assign cam_wAddr  = waddr_q;
    assign cam_wPatt  = wpatt_q;
    assign cam_mPatt  = mpatt_q;

`ifdef BCAM_SCHED_STATS_EN
    logic [15:0] stat_wr_q;
    logic [15:0] stat_mt_q;
    logic [15:0] stat_hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wr_q  <= '0;
            stat_mt_q  <= '0;
            stat_hit_q <= '0;
        end else begin
            if (w_gnt_q && stat_wr_q != 16'hFFFF)
                stat_wr_q <= stat_wr_q + 16'd1;
            if (vld_q && stat_mt_q != 16'hFFFF)
                stat_mt_q <= stat_mt_q + 16'd1;
            if (vld_q && hit_q && stat_hit_q != 16'hFFFF)
                stat_hit_q <= stat_hit_q + 16'd1;
        end
    end

    assign stat_wr  = stat_wr_q;
    assign stat_mt  = stat_mt_q;
    assign stat_hit = stat_hit_q;
`endif

    a_one_gnt: assert property (@(posedge clk) disable iff (rst)
        !(w_gnt_q && m_gnt_q));
    a_gnt_idle: assert property (@(posedge clk) disable iff (rst)
        (w_gnt_q || m_gnt_q) |-> !busy_q);
    a_wenb_busy: assert property (@(posedge clk) disable iff (rst)
        wenb_q |-> busy_q);

endmodule

// File: tb/tb_bcam_req_sched.sv
// tb_bcam_req_sched: scoreboard bench for bcam_req_sched with a behavioural CAM core.
// Stats checks are compiled in when BCAM_SCHED_STATS_EN is defined.
module tb_bcam_req_sched;

    localparam int CAMD  = 256;
    localparam int CAMW  = 16;
    localparam int ADDRW = 8;
    localparam int WLAT  = 2;
    localparam int MLAT  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             w_req;
    logic [ADDRW-1:0] w_addr;
    logic [CAMW-1:0]  w_patt;
    logic             w_gnt;
    logic             m_req;
    logic [CAMW-1:0]  m_patt;
    logic             m_gnt;
    logic             m_rsp_vld;
    logic             m_rsp_hit;
    logic [ADDRW-1:0] m_rsp_addr;
    logic             busy;
    logic             cam_wEnb;
    logic [ADDRW-1:0] cam_wAddr;
    logic [CAMW-1:0]  cam_wPatt;
    logic [CAMW-1:0]  cam_mPatt;
    logic             cam_match;
    logic [ADDRW-1:0] cam_mAddr;
`ifdef BCAM_SCHED_STATS_EN
    logic [15:0]      stat_wr;
    logic [15:0]      stat_mt;
    logic [15:0]      stat_hit;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcam_req_sched #(
        .CAMD(CAMD), .CAMW(CAMW), .WLAT(WLAT), .MLAT(MLAT)
    ) dut (
        .clk(clk), .rst(rst),
        .w_req(w_req), .w_addr(w_addr), .w_patt(w_patt), .w_gnt(w_gnt),
        .m_req(m_req), .m_patt(m_patt), .m_gnt(m_gnt),
        .m_rsp_vld(m_rsp_vld), .m_rsp_hit(m_rsp_hit), .m_rsp_addr(m_rsp_addr),
        .busy(busy),
        .cam_wEnb(cam_wEnb), .cam_wAddr(cam_wAddr), .cam_wPatt(cam_wPatt),
        .cam_mPatt(cam_mPatt), .cam_match(cam_match), .cam_mAddr(cam_mAddr)
`ifdef BCAM_SCHED_STATS_EN
        ,
        .stat_wr(stat_wr), .stat_mt(stat_mt), .stat_hit(stat_hit)
`endif
    );

    // behavioural core: lowest matching entry wins, result valid MLAT-1 cycles after mPatt
    logic [CAMW-1:0]  cm_mem [CAMD];
    logic [CAMD-1:0]  cm_vld;
    logic             cm_hit_c;
    logic [ADDRW-1:0] cm_addr_c;
    logic [1:0]       hit_pipe;
    logic [ADDRW-1:0] addr_p0;
    logic [ADDRW-1:0] addr_p1;

    always @(posedge clk) begin
        if (rst) begin
            cm_vld <= '0;
        end else if (cam_wEnb) begin
            cm_vld[cam_wAddr] <= 1'b1;
            cm_mem[cam_wAddr] <= cam_wPatt;
        end
    end

    always_comb begin
        cm_hit_c  = 1'b0;
        cm_addr_c = '0;
        for (int i = CAMD - 1; i >= 0; i--) begin
            if (cm_vld[i] && cm_mem[i] == cam_mPatt) begin
                cm_hit_c  = 1'b1;
                cm_addr_c = ADDRW'(i);
            end
        end
    end

    always @(posedge clk) begin
        hit_pipe <= {hit_pipe[0], cm_hit_c};
        addr_p0  <= cm_addr_c;
        addr_p1  <= addr_p0;
    end

    assign cam_match = hit_pipe[1];
    assign cam_mAddr = addr_p1;

    logic [2*CAMW+2*ADDRW+5:0] outs_all;
    assign outs_all = {w_gnt, m_gnt, m_rsp_vld, m_rsp_hit, m_rsp_addr, busy,
                       cam_wEnb, cam_wAddr, cam_wPatt, cam_mPatt};

    // reference content as seen by granted writes, and expected responses
    logic [CAMW-1:0]  ref_mem [CAMD];
    logic [CAMD-1:0]  ref_vld;
    logic [ADDRW:0]   sb_q [$];

    function automatic logic [ADDRW:0] ref_lookup(input logic [CAMW-1:0] p);
        logic [ADDRW:0] r;
        r = '0;
        for (int i = CAMD - 1; i >= 0; i--)
            if (ref_vld[i] && ref_mem[i] == p) r = {1'b1, ADDRW'(i)};
        return r;
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        w_req = 1'b0;
        m_req = 1'b0;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        ref_vld = '0;
        sb_q.delete();
    endtask

    task automatic wait_gnt(input bit want_w, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            n++;
            ok = want_w ? w_gnt : m_gnt;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            n++;
            ok = m_rsp_vld;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        w_req  = 1'b1;
        m_req  = 1'b1;
        w_addr = 8'h33;
        w_patt = 16'h3333;
        m_patt = 16'h3333;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (outs_all !== '0) begin
                errors++;
                $display("FAIL reset_outs cyc%0d got=%h exp=0", k, outs_all);
            end
        end
        w_req   = 1'b0;
        m_req   = 1'b0;
        rst     = 1'b0;
        ref_vld = '0;
        sb_q.delete();
        @(negedge clk);
        checks++;
        if (outs_all !== '0) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=0", outs_all);
        end
    endtask

    task automatic test_write_timing();
        bit ok;
        logic [ADDRW+CAMW+1:0] obs, exp;
        w_addr = 8'h05;
        w_patt = 16'hA5A5;
        w_req  = 1'b1;
        wait_gnt(1'b1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wr_gnt_timeout got=0 exp=1");
            w_req = 1'b0;
            return;
        end
        checks++;
        if ({cam_wEnb, busy, m_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL wr_at_T got=%b exp=000", {cam_wEnb, busy, m_gnt});
        end
        ref_mem[8'h05] = 16'hA5A5;
        ref_vld[8'h05] = 1'b1;
        w_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            obs = {cam_wEnb, busy, cam_wAddr, cam_wPatt};
            exp = {k == 1, k <= WLAT, 8'h05, 16'hA5A5};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL wr_T+%0d got=%h exp=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_match_hit();
        bit ok;
        logic [ADDRW:0] e;
        m_patt = 16'hA5A5;
        m_req  = 1'b1;
        wait_gnt(1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mt_gnt_timeout got=0 exp=1");
            m_req = 1'b0;
            return;
        end
        sb_q.push_back(ref_lookup(m_patt));
        m_req = 1'b0;
        for (int k = 1; k <= MLAT + 2; k++) begin
            @(negedge clk);
            if (k <= MLAT) begin
                checks++;
                if ({m_rsp_vld, busy, m_gnt} !== 3'b010) begin
                    errors++;
                    $display("FAIL mt_T+%0d got=%b exp=010", k, {m_rsp_vld, busy, m_gnt});
                end
            end else if (k == MLAT + 1) begin
                checks++;
                if ({m_rsp_vld, busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL mt_rsp_time got=%b exp=10", {m_rsp_vld, busy});
                end
                e = sb_q.pop_front();
                checks++;
                if ({m_rsp_hit, m_rsp_addr} !== e) begin
                    errors++;
                    $display("FAIL mt_hit_rsp got=%h exp=%h", {m_rsp_hit, m_rsp_addr}, e);
                end
                checks++;
                if ({m_rsp_hit, m_rsp_addr} !== {1'b1, 8'h05}) begin
                    errors++;
                    $display("FAIL mt_hit_plan got=%h exp=105", {m_rsp_hit, m_rsp_addr});
                end
            end else begin
                checks++;
                if ({m_rsp_vld, m_rsp_hit, m_rsp_addr} !== {2'b01, 8'h05}) begin
                    errors++;
                    $display("FAIL mt_rsp_hold got=%h exp=105", {m_rsp_vld, m_rsp_hit, m_rsp_addr});
                end
            end
        end
    endtask

    task automatic test_match_miss();
        bit ok;
        logic [ADDRW:0] e;
        m_patt = 16'hDEAD;
        m_req  = 1'b1;
        wait_gnt(1'b0, ok);
        m_req = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL miss_gnt_timeout got=0 exp=1");
            return;
        end
        sb_q.push_back(ref_lookup(m_patt));
        wait_rsp(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL miss_rsp_timeout got=0 exp=1");
            sb_q.delete();
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if ({m_rsp_hit, m_rsp_addr} !== e) begin
            errors++;
            $display("FAIL miss_rsp got=%h exp=%h", {m_rsp_hit, m_rsp_addr}, e);
        end
    endtask

    task automatic test_write_then_match();
        bit ok;
        int n;
        logic [ADDRW:0] e;
        w_addr = 8'h07;
        w_patt = 16'h1234;
        w_req  = 1'b1;
        wait_gnt(1'b1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wtm_wgnt_timeout got=0 exp=1");
            w_req = 1'b0;
            return;
        end
        ref_mem[8'h07] = 16'h1234;
        ref_vld[8'h07] = 1'b1;
        w_req  = 1'b0;
        m_patt = 16'h1234;
        m_req  = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            n++;
            ok = m_gnt;
        end
        m_req = 1'b0;
        checks++;
        if (n != WLAT + 1) begin
            errors++;
            $display("FAIL wtm_gnt_gap got=%0d exp=%0d", n, WLAT + 1);
        end
        if (!ok) return;
        sb_q.push_back(ref_lookup(m_patt));
        wait_rsp(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wtm_rsp_timeout got=0 exp=1");
            sb_q.delete();
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if ({m_rsp_hit, m_rsp_addr} !== e || e !== {1'b1, 8'h07}) begin
            errors++;
            $display("FAIL wtm_rsp got=%h exp=%h", {m_rsp_hit, m_rsp_addr}, e);
        end
    endtask

    task automatic test_contention();
        int ng, last_t, gap;
        bit last_w, upd, exp_w;
        logic [ADDRW:0] e;
        do_reset();
        w_addr = 8'h10;
        w_patt = 16'h1111;
        m_patt = 16'h0000;
        w_req  = 1'b1;
        m_req  = 1'b1;
        ng     = 0;
        last_t = 0;
        last_w = 1'b0;
        upd    = 1'b0;
        for (int c = 0; c < 60 && !(ng == 4 && sb_q.size() == 0); c++) begin
            @(negedge clk);
            if (m_rsp_vld) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL cont_rsp_unexpected got=1 exp=0");
                end else begin
                    e = sb_q.pop_front();
                    if ({m_rsp_hit, m_rsp_addr} !== e) begin
                        errors++;
                        $display("FAIL cont_rsp got=%h exp=%h", {m_rsp_hit, m_rsp_addr}, e);
                    end
                end
            end
            if (w_gnt || m_gnt) begin
                checks++;
                if (w_gnt && m_gnt) begin
                    errors++;
                    $display("FAIL cont_both_gnt got=11 exp=one");
                end
                exp_w = (ng % 2 == 0);
                checks++;
                if (w_gnt !== exp_w) begin
                    errors++;
                    $display("FAIL cont_order op%0d got_w=%b exp_w=%b", ng, w_gnt, exp_w);
                end
                if (ng > 0) begin
                    gap = (last_w ? WLAT : MLAT) + 1;
                    checks++;
                    if (c - last_t != gap) begin
                        errors++;
                        $display("FAIL cont_gap op%0d got=%0d exp=%0d", ng, c - last_t, gap);
                    end
                end
                if (w_gnt) begin
                    ref_mem[w_addr] = w_patt;
                    ref_vld[w_addr] = 1'b1;
                    upd = 1'b1;
                end
                if (m_gnt) sb_q.push_back(ref_lookup(m_patt));
                last_w = w_gnt;
                last_t = c;
                ng++;
                if (ng == 4) begin
                    w_req = 1'b0;
                    m_req = 1'b0;
                end
            end else if (upd) begin
                m_patt = w_patt;
                w_addr = w_addr + 8'h01;
                w_patt = w_patt + 16'h1111;
                upd    = 1'b0;
            end
        end
        w_req = 1'b0;
        m_req = 1'b0;
        checks++;
        if (ng != 4 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL cont_done got=%0d/%0d exp=4/0", ng, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid_match();
        bit ok;
        int nv;
        m_patt = 16'h2222;
        m_req  = 1'b1;
        wait_gnt(1'b0, ok);
        m_req = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rmm_gnt_timeout got=0 exp=1");
            return;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (outs_all !== '0) begin
            errors++;
            $display("FAIL rmm_outs got=%h exp=0", outs_all);
        end
        @(negedge clk);
        rst     = 1'b0;
        ref_vld = '0;
        sb_q.delete();
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (m_rsp_vld) nv++;
        end
        checks++;
        if (nv != 0) begin
            errors++;
            $display("FAIL rmm_stale_rsp got=%0d exp=0", nv);
        end
        w_addr = 8'h03;
        w_patt = 16'h0303;
        m_patt = 16'h0303;
        w_req  = 1'b1;
        m_req  = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = w_gnt || m_gnt;
        end
        checks++;
        if ({w_gnt, m_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL rmm_rr_reset got=%b exp=10", {w_gnt, m_gnt});
        end
        w_req = 1'b0;
        m_req = 1'b0;
        repeat (MLAT + 2) @(negedge clk);
    endtask

`ifdef BCAM_SCHED_STATS_EN
    task automatic issue_write(input logic [ADDRW-1:0] a, input logic [CAMW-1:0] p,
                               output bit ok);
        w_addr = a;
        w_patt = p;
        w_req  = 1'b1;
        wait_gnt(1'b1, ok);
        w_req = 1'b0;
        repeat (WLAT) @(negedge clk);
    endtask

    task automatic issue_match(input logic [CAMW-1:0] p, output bit ok);
        bit g;
        m_patt = p;
        m_req  = 1'b1;
        wait_gnt(1'b0, g);
        m_req = 1'b0;
        ok = 1'b0;
        if (g) wait_rsp(ok);
    endtask

    task automatic test_stats();
        bit ok1, ok2, ok3, ok4, ok5;
        do_reset();
        issue_write(8'h01, 16'h0101, ok1);
        issue_write(8'h02, 16'h0202, ok2);
        issue_write(8'h03, 16'h0303, ok3);
        issue_match(16'h0202, ok4);
        issue_match(16'hBEEF, ok5);
        repeat (2) @(negedge clk);
        checks++;
        if (!(ok1 && ok2 && ok3 && ok4 && ok5)) begin
            errors++;
            $display("FAIL stats_ops_timeout got=%b exp=11111", {ok1, ok2, ok3, ok4, ok5});
        end
        checks++;
        if ({stat_wr, stat_mt, stat_hit} !== {16'd3, 16'd2, 16'd1}) begin
            errors++;
            $display("FAIL stats_counts got=%0d/%0d/%0d exp=3/2/1", stat_wr, stat_mt, stat_hit);
        end
        force dut.stat_wr_q = 16'hFFFF;
        @(negedge clk);
        release dut.stat_wr_q;
        issue_write(8'h04, 16'h0404, ok1);
        repeat (2) @(negedge clk);
        checks++;
        if (stat_wr !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_sat got=%h exp=ffff", stat_wr);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        w_req  = 1'b0;
        m_req  = 1'b0;
        w_addr = '0;
        w_patt = '0;
        m_patt = '0;
        ref_vld = '0;
        do_reset();
        test_reset();
        test_write_timing();
        test_match_hit();
        test_match_miss();
        test_write_then_match();
        test_contention();
        test_reset_mid_match();
`ifdef BCAM_SCHED_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcam_req_sched.md
Name: bcam_req_sched

Overview:
- Sequencer/arbiter placed in front of one binary CAM core (CAMD entries × CAMW bits).
- Serialises two requesters onto the core: a write client and a match client, each with a req/gnt handshake.
- Drives the core's wEnb/wAddr/wPatt/mPatt. Captures match/mAddr after a fixed latency and returns it as a one-cycle response.
- Enforces write-before-match ordering, so a match never observes a partially updated entry.

Parameters:
- CAMD, 256, CAM depth (entries).
- CAMW, 16, pattern width in bits.
- ADDRW, $clog2(CAMD), address width (derived; not overridden).
- WLAT, 2, core write-update cycles (≥1); wAddr/wPatt held stable this long.
- MLAT, 3, cycles from mPatt change to valid match/mAddr at core outputs (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- w_req  in  1  write request; held until w_gnt
- w_addr  in  ADDRW  write address
- w_patt  in  CAMW  write pattern
- w_gnt  out  1  one-cycle pulse; w_addr/w_patt sampled this cycle
- m_req  in  1  match request; held until m_gnt
- m_patt  in  CAMW  match pattern
- m_gnt  out  1  one-cycle pulse; m_patt sampled this cycle
- m_rsp_vld  out  1  one-cycle pulse; result valid
- m_rsp_hit  out  1  match flag
- m_rsp_addr  out  ADDRW  matching address
- busy  out  1  core operation in flight
- cam_wEnb  out  1  to core
- cam_wAddr  out  ADDRW  to core
- cam_wPatt  out  CAMW  to core
- cam_mPatt  out  CAMW  to core
- cam_match  in  1  from core
- cam_mAddr  in  ADDRW  from core

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; FSM is IDLE; round-robin pointer favours write; internal counters are 0.
- FSM states:
  - IDLE: grants only in this state. Exactly one grant per cycle.
    - Only w_req high → WRITE.
    - Only m_req high → MATCH.
    - Both high → round-robin: grant the side not granted last. Pointer updates on every grant.
  - WRITE: entered at T+1 (T = grant cycle).
    - cam_wEnb = 1 for cycle T+1 only.
    - cam_wAddr/cam_wPatt are loaded at T+1 and held through T+WLAT, and remain holding after.
    - busy = 1 for T+1..T+WLAT. Return to IDLE; next grant possible at T+WLAT+1.
  - MATCH: cam_mPatt is loaded at T+1 and held until the next match grant.
    - Down-counter of MLAT. Core outputs are sampled at T+MLAT.
    - m_rsp_vld/m_rsp_hit/m_rsp_addr are registered at T+MLAT+1. m_rsp_hit/m_rsp_addr hold until the next response.
    - busy = 1 for T+1..T+MLAT. Next grant possible at T+MLAT+1, coincident with m_rsp_vld.
- Ordering: operations complete strictly in grant order. A match granted after a write sees that write's content.
- Requester dropping req before gnt: legal; no grant is issued.
- Requester holding req after gnt: treated as a new request.
- Simultaneous rst and req: rst wins; no grant.
- Reset mid-WRITE:
  - cam_wEnb forced 0; cam_wAddr/cam_wPatt → 0.
  - The partial core update is the core's concern; the scheduler issues nothing further.
- Reset mid-MATCH: pending response discarded; m_rsp_vld stays 0.
- Counter width: $clog2(max(WLAT,MLAT)+1); no wrap condition is reachable.

Optional Feature:
- Macro: BCAM_SCHED_STATS_EN.
- Defined: adds three output ports, each a 16-bit saturating counter (holds at 16'hFFFF), cleared by rst:
  - stat_wr: increments on w_gnt.
  - stat_mt: increments on m_rsp_vld.
  - stat_hit: increments on m_rsp_vld & m_rsp_hit.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write grant and timing: after rst, w_req with w_addr=8'h05, w_patt=16'hA5A5 → w_gnt at T; cam_wEnb=1 only at T+1; cam_wAddr=05 / cam_wPatt=A5A5 held T+1..T+2; busy high T+1..T+2.
- Match hit: m_req, m_patt=16'hA5A5, with the core model returning match=1, mAddr=05 at T+3 → m_rsp_vld pulse at T+4 with hit=1, addr=8'h05; m_gnt earliest at T+4.
- Contention: w_req and m_req high together from IDLE after reset → grants alternate write, match, write, match over 4 operations; no cycle has both gnt high.
- Write-then-match ordering: back-to-back write(addr 7, 16'h1234) then match(16'h1234) → match grant not before write grant+WLAT+1; response hit=1, addr=8'h07.
- Reset mid-match: rst asserted at T+2 of a match → no m_rsp_vld afterwards; all outputs 0; next request with both req high is granted to write.
- Stats (BCAM_SCHED_STATS_EN): 3 writes, 2 matches with 1 hit → stat_wr=3, stat_mt=2, stat_hit=1; forced saturation at 16'hFFFF holds.
